// File: rtl/ecc_pkg.sv
// Shared definitions for the T-register readout block: select-bit
// positions, register geometry, FSM encoding and a select helper.
package ecc_pkg;

  localparam int SEL_X   = 0;
  localparam int SEL_Y   = 1;
  localparam int SEL_S   = 2;
  localparam int T_BYTES = 32;
  localparam int T_BITS  = T_BYTES * 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Index of the first register to send, in x -> y -> s order.
  // Callers only use the result when at least one bit is set.
  function automatic logic [1:0] first_sel(input logic [2:0] sel);
    if (sel[SEL_X])      return 2'(SEL_X);
    else if (sel[SEL_Y]) return 2'(SEL_Y);
    else                 return 2'(SEL_S);
  endfunction

endpackage

// File: rtl/ecc_t_rdout.sv
// Byte-serial readout of the x/y/s T-registers over a valid/ready port.
// A start snapshots all three registers, then the selected ones are
// streamed MSB-first through a single 256-bit shifter with no bubbles.
module ecc_t_rdout
  import ecc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_start,
  input  logic [2:0]        rd_sel,
  input  logic              rd_clr_after,
  input  logic              rd_abort,
  input  logic [T_BITS-1:0] x,
  input  logic [T_BITS-1:0] y,
  input  logic [T_BITS-1:0] s,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic              t_clr
);

  state_t                  r_state;
  logic [2:0][T_BITS-1:0]  r_snap;      // indexed by SEL_X/SEL_Y/SEL_S
  logic [T_BITS-1:0]       r_shift;
  logic [4:0]              r_cnt;
  logic [2:0]              r_pend;      // selected registers not yet loaded
  logic                    r_clr;
  logic                    r_tx_valid;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_t_clr;

  logic                    w_accept;
  logic                    w_last;
  logic [1:0]              w_start_idx;
  logic [1:0]              w_next_idx;
  logic [T_BITS-1:0]       w_start_word;

  assign w_accept    = r_tx_valid & tx_ready;
  assign w_last      = (r_cnt == 5'(T_BYTES - 1));
  assign w_start_idx = first_sel(rd_sel);
  assign w_next_idx  = first_sel(r_pend);

  // Pick the first selected register straight from the inputs so the
  // first byte is presented the cycle after the start.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // through the case can leave it unassigned and infer a latch.
    w_start_word = x;
    case (w_start_idx)
      2'(SEL_Y): w_start_word = y;
      2'(SEL_S): w_start_word = s;
      default:   w_start_word = x;
    endcase
  end

  // Readout FSM with registered outputs; abort outranks everything but reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the wide snapshot and shifter are flops, not a RAM, so they
      // take the async reset like any other state and restart clean.
      r_state    <= ST_IDLE;
      r_snap     <= '0;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_pend     <= '0;
      r_clr      <= 1'b0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_t_clr    <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every branch reads the pre-edge
      // state and the one-cycle pulses below can be defaulted safely.
      r_done  <= 1'b0;
      r_t_clr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (rd_start) begin
            r_snap <= {s, y, x};
            r_clr  <= rd_clr_after;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            if (rd_sel == 3'b000) begin
              r_state <= ST_DONE;
              r_pend  <= '0;
              r_done  <= 1'b1;
              r_t_clr <= rd_clr_after;
            end else begin
              r_state                 <= ST_SEND;
              r_tx_valid              <= 1'b1;
              r_shift                 <= w_start_word;
              r_pend                  <= rd_sel;
              r_pend[w_start_idx]     <= 1'b0;
            end
          end
        end

        ST_SEND: begin
          if (rd_abort) begin
            r_state    <= ST_IDLE;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_shift    <= '0;
            r_pend     <= '0;
            r_cnt      <= '0;
          end else if (w_accept) begin
            r_cnt <= r_cnt + 5'd1;   // wraps 31 -> 0 at a register boundary
            if (!w_last) begin
              r_shift <= r_shift << 8;
            end else if (r_pend != 3'b000) begin
              // Next register loads on the same edge: no bubble.
              r_shift             <= r_snap[w_next_idx];
              r_pend[w_next_idx]  <= 1'b0;
            end else begin
              r_state    <= ST_DONE;
              r_tx_valid <= 1'b0;
              r_shift    <= '0;
              r_done     <= 1'b1;
              r_t_clr    <= r_clr;
            end
          end
        end

        ST_DONE: begin
          // Single-cycle state; an abort here leads to the same place.
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state    <= ST_IDLE;
          r_tx_valid <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign tx_data  = r_shift[T_BITS-1 -: 8];
  assign tx_valid = r_tx_valid;
  assign busy     = r_busy;
  assign done     = r_done;
  assign t_clr    = r_t_clr;

endmodule

// File: tb/tb_ecc_t_rdout.sv
// Self-checking bench for ecc_t_rdout: a byte-queue model of the readout
// is compared against the DUT every cycle, plus literal spot checks.
module tb_ecc_t_rdout;

  logic         clk;
  logic         rst_n;
  logic         rd_start;
  logic [2:0]   rd_sel;
  logic         rd_clr_after;
  logic         rd_abort;
  logic [255:0] x, y, s;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         busy;
  logic         done;
  logic         t_clr;

  ecc_t_rdout dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_start     (rd_start),
    .rd_sel       (rd_sel),
    .rd_clr_after (rd_clr_after),
    .rd_abort     (rd_abort),
    .x            (x),
    .y            (y),
    .s            (s),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .done         (done),
    .t_clr        (t_clr)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model: a queue of bytes still owed ------
  logic [7:0] m_q[$];
  logic       m_valid = 1'b0;
  logic       m_done  = 1'b0;
  logic       m_tclr  = 1'b0;
  logic       m_clr   = 1'b0;

  function automatic logic [255:0] pick(input int r);
    if (r == 0)      return x;
    else if (r == 1) return y;
    else             return s;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_q.delete();
        m_valid = 1'b0; m_done = 1'b0; m_tclr = 1'b0; m_clr = 1'b0;
      end else if ((m_valid || m_done) && rd_abort) begin
        m_q.delete();
        m_valid = 1'b0; m_done = 1'b0; m_tclr = 1'b0;
      end else if (m_done) begin
        m_done = 1'b0; m_tclr = 1'b0;
      end else if (m_valid) begin
        if (tx_ready) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin
            m_valid = 1'b0; m_done = 1'b1; m_tclr = m_clr;
          end
        end
      end else if (rd_start) begin
        m_clr = rd_clr_after;
        for (int r = 0; r < 3; r++) begin
          if (rd_sel[r]) begin
            logic [255:0] w;
            w = pick(r);
            for (int i = 0; i < 32; i++) m_q.push_back(w[255 - 8*i -: 8]);
          end
        end
        if (m_q.size() == 0) begin
          m_done = 1'b1; m_tclr = m_clr;
        end else begin
          m_valid = 1'b1;
        end
      end
    end
  end

  // ---------------- compare process ------------------------------------
  logic chk_en = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && chk_en) begin
        check("tx_valid", 32'(tx_valid), 32'(m_valid));
        check("busy",     32'(busy),     32'(m_valid | m_done));
        check("done",     32'(done),     32'(m_done));
        check("t_clr",    32'(t_clr),    32'(m_tclr));
        if (m_valid && m_q.size() > 0) check("tx_data", 32'(tx_data), 32'(m_q[0]));
      end
    end
  end

  // ---------------- observation counters for literal checks ------------
  int         acc_cnt  = 0;
  int         done_cnt = 0;
  int         tclr_cnt = 0;
  int         both_cnt = 0;
  logic [7:0] last_byte = 8'h00;
  int         hist[256];
  initial begin
    for (int i = 0; i < 256; i++) hist[i] = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (tx_valid && tx_ready && !rd_abort) begin
          acc_cnt++;
          last_byte = tx_data;
          hist[tx_data]++;
        end
        if (done) done_cnt++;
        if (t_clr) tclr_cnt++;
        if (done && t_clr) both_cnt++;
      end
    end
  end

  // ---------------- tx_ready driver: always-on or 1,0,0,1 pattern -------
  logic       rdy_mode = 1'b0;
  logic [3:0] rdy_pat  = 4'b1001;
  initial begin
    int phase;
    phase    = 0;
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode) begin
        tx_ready = rdy_pat[phase];
        phase    = (phase + 1) % 4;
      end else begin
        tx_ready = 1'b1;
        phase    = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus helpers ------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] fill(input logic [7:0] b);
    return {32{b}};
  endfunction

  function automatic logic [255:0] ascending(input logic [7:0] base);
    logic [255:0] w;
    for (int i = 0; i < 32; i++) w[255 - 8*i -: 8] = base + 8'(i);
    return w;
  endfunction

  task automatic start_rd(input logic [2:0] sel, input logic clr);
    step();
    rd_start     = 1'b1;
    rd_sel       = sel;
    rd_clr_after = clr;
    step();
    rd_start     = 1'b0;
    rd_sel       = 3'b000;
    rd_clr_after = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  // ---------------- directed tests --------------------------------------
  initial begin
    int a0, d0, t0, b0, h0, h1, h2;
    rst_n = 1'b0; rd_start = 1'b0; rd_sel = 3'b000; rd_clr_after = 1'b0;
    rd_abort = 1'b0; x = '0; y = '0; s = '0;

    repeat (2) @(negedge clk);
    check("rst tx_valid", 32'(tx_valid), 32'd0);
    check("rst tx_data",  32'(tx_data),  32'd0);
    check("rst busy",     32'(busy),     32'd0);
    check("rst done",     32'(done),     32'd0);
    check("rst t_clr",    32'(t_clr),    32'd0);
    step();
    rst_n  = 1'b1;
    chk_en = 1'b1;
    step();

    // x ascending, x only, full-rate; a stray start mid-transfer is ignored
    x = ascending(8'h00); y = fill(8'h77); s = fill(8'h88);
    a0 = acc_cnt; d0 = done_cnt; t0 = tclr_cnt;
    start_rd(3'b001, 1'b0);
    @(negedge clk);
    check("t1 first valid", 32'(tx_valid), 32'd1);
    check("t1 first byte",  32'(tx_data),  32'h00);
    step(); step();
    rd_start = 1'b1; rd_sel = 3'b111;
    step();
    rd_start = 1'b0; rd_sel = 3'b000;
    wait_idle(100, "t1 timeout");
    check("t1 accepted", 32'(acc_cnt - a0),  32'd32);
    check("t1 last byte", 32'(last_byte),    32'h1F);
    check("t1 done",     32'(done_cnt - d0), 32'd1);
    check("t1 t_clr",    32'(tclr_cnt - t0), 32'd0);

    // all three registers, clear requested
    x = fill(8'hAA); y = fill(8'hBB); s = fill(8'hCC);
    a0 = acc_cnt; d0 = done_cnt; b0 = both_cnt;
    h0 = hist[8'hAA]; h1 = hist[8'hBB]; h2 = hist[8'hCC];
    start_rd(3'b111, 1'b1);
    @(negedge clk);
    check("t2 first byte", 32'(tx_data), 32'hAA);
    wait_idle(200, "t2 timeout");
    check("t2 accepted",  32'(acc_cnt - a0),      32'd96);
    check("t2 x bytes",   32'(hist[8'hAA] - h0),  32'd32);
    check("t2 y bytes",   32'(hist[8'hBB] - h1),  32'd32);
    check("t2 s bytes",   32'(hist[8'hCC] - h2),  32'd32);
    check("t2 done",      32'(done_cnt - d0),     32'd1);
    check("t2 done+clr",  32'(both_cnt - b0),     32'd1);

    // x and s with stalls
    x = ascending(8'h40); y = fill(8'hFF); s = ascending(8'hC0);
    a0 = acc_cnt; h0 = hist[8'hFF];
    rdy_mode = 1'b1;
    start_rd(3'b101, 1'b0);
    wait_idle(400, "t3 timeout");
    rdy_mode = 1'b0;
    check("t3 accepted", 32'(acc_cnt - a0),     32'd64);
    check("t3 no y",     32'(hist[8'hFF] - h0), 32'd0);
    check("t3 last byte", 32'(last_byte),       32'hDF);

    // snapshot isolation
    x = fill(8'h11);
    h0 = hist[8'h11]; h1 = hist[8'h22];
    start_rd(3'b001, 1'b0);
    x = fill(8'h22);
    wait_idle(100, "t4 timeout");
    check("t4 0x11 bytes", 32'(hist[8'h11] - h0), 32'd32);
    check("t4 0x22 bytes", 32'(hist[8'h22] - h1), 32'd0);

    // abort after 10 accepted bytes, then restart
    x = ascending(8'h40);
    a0 = acc_cnt; d0 = done_cnt; t0 = tclr_cnt;
    start_rd(3'b001, 1'b1);
    for (int i = 0; i < 100; i++) begin
      if (acc_cnt - a0 >= 10) break;
      step();
    end
    check("t5 reached 10", 32'(acc_cnt - a0), 32'd10);
    rd_abort = 1'b1;
    step();
    rd_abort = 1'b0;
    @(negedge clk);
    check("t5 valid after abort", 32'(tx_valid), 32'd0);
    check("t5 busy after abort",  32'(busy),     32'd0);
    step(); step();
    check("t5 no done",  32'(done_cnt - d0), 32'd0);
    check("t5 no t_clr", 32'(tclr_cnt - t0), 32'd0);
    start_rd(3'b001, 1'b0);
    @(negedge clk);
    check("t5 restart byte0", 32'(tx_data), 32'h40);
    wait_idle(100, "t5 timeout");

    // empty select with clear
    a0 = acc_cnt;
    start_rd(3'b000, 1'b1);
    @(negedge clk);
    check("t6 done",     32'(done),     32'd1);
    check("t6 t_clr",    32'(t_clr),    32'd1);
    check("t6 no valid", 32'(tx_valid), 32'd0);
    wait_idle(10, "t6 timeout");
    check("t6 no bytes", 32'(acc_cnt - a0), 32'd0);

    // reset in the middle of a transfer
    x = fill(8'h5A); y = fill(8'h6B); s = fill(8'h7C);
    d0 = done_cnt; t0 = tclr_cnt;
    start_rd(3'b111, 1'b1);
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    check("t7 tx_valid", 32'(tx_valid), 32'd0);
    check("t7 tx_data",  32'(tx_data),  32'd0);
    check("t7 busy",     32'(busy),     32'd0);
    check("t7 done",     32'(done),     32'd0);
    check("t7 t_clr",    32'(t_clr),    32'd0);
    step(); step();
    rst_n = 1'b1;
    repeat (4) step();
    check("t7 no done",  32'(done_cnt - d0), 32'd0);
    check("t7 no t_clr", 32'(tclr_cnt - t0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
